ps2_keycode_decoder: RTL and testbench
======================================

Name: ps2_keycode_decoder

Overview:
- Keyboard-side front end for the game: receives PS/2 Set-2 scancode frames and produces the held-key `keycode` bus consumed by the game state controller.
- Keycodes use USB HID usage values: 04 = A, 07 = D, 16 = S, 1A = W, 2C = space.
- Tracks make/break/extended prefixes so that `keycode` holds the most recent pressed key and clears to 00 on that key's release.
- Emits a single-cycle `shoot_bullet` pulse on each fresh space press.

Parameters:
- FILTER_LEN, 8: number of consecutive identical sync'd `ps2_clk` samples required before a level change is accepted.
- TIMEOUT_CYCLES, 50000: Clk cycles without a PS/2 falling edge mid-frame before the frame is aborted (1 ms at 50 MHz).

Ports:
- Clk  input  1  system clock (50 MHz); all state on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock line, asynchronous.
- ps2_data  input  1  raw PS/2 data line, asynchronous.
- keycode  output  8  HID code of the currently held key; 00 = none.
- key_valid  output  1  one-cycle pulse whenever `keycode` changes value.
- shoot_bullet  output  1  one-cycle pulse on space make when `keycode` was not already 2C.
- frame_err  output  1  one-cycle pulse on parity, stop-bit or timeout error.

Behaviour:
- Reset values:
  - `keycode` = 00; `key_valid`, `shoot_bullet`, `frame_err` = 0.
  - Both FSMs return to idle; synchronizers, filter and counters cleared.
  - Reset mid-frame discards the partial byte.
- Input conditioning:
  - Two-flop synchronizer on each line.
  - `ps2_clk` passes through a FILTER_LEN debounce before edge detection.
  - A falling edge of the filtered clock is a one-cycle strobe `fe`.
  - `ps2_data` (sync'd) is sampled on `fe`.
- Frame FSM (sub-module), states RX_IDLE, RX_DATA, RX_PARITY, RX_STOP:
  - RX_IDLE: on `fe` with data=0 (start bit), go to RX_DATA and set bitcnt=0. On `fe` with data=1, stay; no error.
  - RX_DATA: shift in LSB first on each `fe`; after bitcnt=7 go to RX_PARITY.
  - RX_PARITY: capture the parity bit, go to RX_STOP.
  - RX_STOP:
    - Stop=1 and odd parity over data+parity: pulse `byte_valid` with `byte` in the cycle after the stop `fe`.
    - Otherwise: pulse `frame_err`, drop the byte.
    - Either way return to RX_IDLE.
  - Timeout counter resets on every `fe`. In any non-idle state, reaching TIMEOUT_CYCLES gives RX_IDLE plus a `frame_err` pulse.
- Scancode FSM, states SC_WAIT, SC_E0, SC_F0, SC_E0F0, advanced only on `byte_valid`:
  - SC_WAIT: E0 goes to SC_E0; F0 goes to SC_F0; any other byte is a base make.
  - SC_E0: F0 goes to SC_E0F0; other byte is an extended make, then SC_WAIT.
  - SC_F0: base break, then SC_WAIT. SC_E0F0: extended break, then SC_WAIT.
  - A repeated E0 in SC_E0 stays in SC_E0.
- Translation (combinational lookup, unmapped = 00):
  - Base: 1C→04, 23→07, 1B→16, 1D→1A, 29→2C, 5A→28, 76→29.
  - Extended: 6B→50, 74→4F, 75→52, 72→51.
- Make handling, with mapped code h≠00:
  - If h≠`keycode`: `keycode`<=h and `key_valid` pulses.
  - If h=2C and the prior `keycode`≠2C, `shoot_bullet` pulses in the same cycle.
  - Typematic repeat (h=`keycode`) produces no pulses. Unmapped makes are ignored.
- Break handling, with mapped h:
  - If h=`keycode`: `keycode`<=00 and `key_valid` pulses.
  - Otherwise ignore; releasing an older key does not clear a newer one.
- Latency: `keycode`, `key_valid` and `shoot_bullet` update exactly 1 Clk after `byte_valid`, i.e. 2 Clk after the stop-bit `fe` strobe.
- A parity-error byte does not advance the scancode FSM; any pending prefix state is kept.

Decomposition:
- Package `game_input_pkg`:
  - HID constants: KEY_NONE, KEY_A, KEY_D, KEY_S, KEY_W, KEY_SPACE, KEY_ENTER, KEY_ESC, KEY_LEFT, KEY_RIGHT, KEY_UP, KEY_DOWN.
  - PS/2 prefix constants PS2_EXT=E0, PS2_BRK=F0.
  - Enums for both FSMs.
- Sub-module `ps2_frame_rx`: synchronizer, filter, edge detect, frame FSM, timeout. Outputs `byte`[7:0], `byte_valid`, `frame_err`.

Test Plan:
- Reset asserted mid-frame (after 4 data bits), then a full frame 1C → `keycode` stays 00 during reset; after release, 1C frame gives `keycode`=04 and one `key_valid` pulse.
- Frames 1D, 1D, 1D (typematic), then F0 1D → `keycode`=1A with a single `key_valid`; after the break, `keycode`=00 with one `key_valid`.
- Frames 29, 29, F0 29, 29 → `shoot_bullet` pulses exactly twice (first make and the make after release); `keycode`=2C at the end.
- Frames 1C, 23, F0 1C → `keycode`=07 after 23 and remains 07 after the A break; then F0 23 gives 00.
- Frames E0 75, E0 F0 75 → `keycode`=52, then 00; no `shoot_bullet`.
- Frame 1C with parity bit flipped → `frame_err` one pulse, `keycode` unchanged. Start bit plus 3 bits then idle for 50000 cycles → `frame_err` pulse; next valid frame 1B decodes to 16.

Source files
------------

// File: rtl/game_input_pkg.sv
// Shared constants, FSM state types and lookup helpers for the PS/2 keyboard
// front end. The package has no ports. It provides the HID usage codes, the
// PS/2 prefix bytes, the enums for both FSMs, the scancode-to-HID translation
// and the odd-parity check.
package game_input_pkg;

    // USB HID usage codes produced on the keycode bus
    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_ESC   = 8'h29;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_UP    = 8'h52;

    // PS/2 Set-2 prefix bytes
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        SC_WAIT = 2'd0,
        SC_E0   = 2'd1,
        SC_F0   = 2'd2,
        SC_E0F0 = 2'd3
    } sc_state_e;

    // Set-2 scancode to HID usage; anything not listed maps to KEY_NONE
    function automatic logic [7:0] ps2_to_hid(input logic ext, input logic [7:0] code);
        logic [7:0] hid;
        hid = KEY_NONE;
        if (ext) begin
            case (code)
                8'h6B:   hid = KEY_LEFT;
                8'h74:   hid = KEY_RIGHT;
                8'h75:   hid = KEY_UP;
                8'h72:   hid = KEY_DOWN;
                default: hid = KEY_NONE;
            endcase
        end else begin
            case (code)
                8'h1C:   hid = KEY_A;
                8'h23:   hid = KEY_D;
                8'h1B:   hid = KEY_S;
                8'h1D:   hid = KEY_W;
                8'h29:   hid = KEY_SPACE;
                8'h5A:   hid = KEY_ENTER;
                8'h76:   hid = KEY_ESC;
                default: hid = KEY_NONE;
            endcase
        end
        return hid;
    endfunction

    // True when data plus parity bit hold an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{par, data};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver. It synchronizes both lines and debounces the clock line.
// Each accepted falling edge of the clock samples the data line. The block then
// assembles 11-bit frames (start, 8 data LSB-first, odd parity, stop).
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   ps2_clk/ps2_data raw asynchronous PS/2 lines
//   rx_byte          last good data byte (valid while byte_valid is high)
//   byte_valid       one-cycle pulse for a good frame
//   frame_err        one-cycle pulse on parity/stop error or mid-frame timeout
module ps2_frame_rx
    import game_input_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]       clk_sync_r;
    logic [1:0]       data_sync_r;
    logic             filt_clk_r;
    logic [FLT_W-1:0] filt_cnt_r;
    logic             fe_s;

    rx_state_e        state_r, state_n;
    logic [2:0]       bitcnt_r, bitcnt_n;
    logic [7:0]       shift_r, shift_n;
    logic             parity_r, parity_n;
    logic [TMO_W-1:0] tmo_r, tmo_n;
    logic [7:0]       byte_r, byte_n;
    logic             valid_r, valid_n;
    logic             err_r, err_n;

    // Two-flop synchronizers on both raw lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_r  <= 2'b00;
            data_sync_r <= 2'b00;
        end else begin
            clk_sync_r  <= {clk_sync_r[0], ps2_clk};
            data_sync_r <= {data_sync_r[0], ps2_data};
        end
    end

    // A level change is accepted only after FILTER_LEN consecutive differing samples.
    // The filtered clock resets to the idle-high bus level so no edge is seen at start-up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_clk_r <= 1'b1;
            filt_cnt_r <= '0;
        end else if (clk_sync_r[1] == filt_clk_r) begin
            filt_cnt_r <= '0;
        end else if (filt_cnt_r == FLT_W'(FILTER_LEN - 1)) begin
            filt_clk_r <= clk_sync_r[1];
            filt_cnt_r <= '0;
        end else begin
            filt_cnt_r <= filt_cnt_r + FLT_W'(1);
        end
    end

    // Falling-edge strobe: the cycle the filter accepts a high-to-low change
    assign fe_s = filt_clk_r && !clk_sync_r[1] && (filt_cnt_r == FLT_W'(FILTER_LEN - 1));

    // Frame FSM state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= RX_IDLE;
            bitcnt_r <= 3'd0;
            shift_r  <= 8'h00;
            parity_r <= 1'b0;
            tmo_r    <= '0;
            byte_r   <= 8'h00;
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_n;
            bitcnt_r <= bitcnt_n;
            shift_r  <= shift_n;
            parity_r <= parity_n;
            tmo_r    <= tmo_n;
            byte_r   <= byte_n;
            valid_r  <= valid_n;
            err_r    <= err_n;
        end
    end

    // Frame FSM next-state, timeout and output pulses
    always_comb begin
        state_n  = state_r;
        bitcnt_n = bitcnt_r;
        shift_n  = shift_r;
        parity_n = parity_r;
        byte_n   = byte_r;
        valid_n  = 1'b0;
        err_n    = 1'b0;

        if (fe_s || state_r == RX_IDLE) begin
            tmo_n = '0;
        end else begin
            tmo_n = tmo_r + TMO_W'(1);
        end

        if (state_r != RX_IDLE && !fe_s && tmo_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_n = RX_IDLE;
            err_n   = 1'b1;
        end else if (fe_s) begin
            case (state_r)
                RX_IDLE: begin
                    if (!data_sync_r[1]) begin
                        state_n  = RX_DATA;
                        bitcnt_n = 3'd0;
                    end else begin
                        state_n  = RX_IDLE;
                    end
                end
                RX_DATA: begin
                    shift_n = {data_sync_r[1], shift_r[7:1]};
                    if (bitcnt_r == 3'd7) begin
                        state_n = RX_PARITY;
                    end else begin
                        bitcnt_n = bitcnt_r + 3'd1;
                    end
                end
                RX_PARITY: begin
                    parity_n = data_sync_r[1];
                    state_n  = RX_STOP;
                end
                RX_STOP: begin
                    state_n = RX_IDLE;
                    if (data_sync_r[1] && odd_parity_ok(shift_r, parity_r)) begin
                        byte_n  = shift_r;
                        valid_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                default: state_n = RX_IDLE;
            endcase
        end else begin
            state_n = state_r;
        end
    end

    assign rx_byte    = byte_r;
    assign byte_valid = valid_r;
    assign frame_err  = err_r;

endmodule

// File: rtl/ps2_keycode_decoder.sv
// PS/2 Set-2 keyboard decoder for the game. It tracks the E0/F0 prefixes and
// keeps the most recently pressed mapped key on keycode. It clears keycode when
// that key is released and pulses shoot_bullet on each fresh space press.
// Ports:
//   Clk, Reset       system clock, asynchronous active-high reset
//   ps2_clk/ps2_data raw PS/2 lines
//   keycode          HID code of the held key (00 = none)
//   key_valid        one-cycle pulse when keycode changes
//   shoot_bullet     one-cycle pulse on space make while space was not held
//   frame_err        one-cycle pulse on a bad or timed-out frame
module ps2_keycode_decoder
    import game_input_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_valid,
    output logic       shoot_bullet,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       byte_valid;

    sc_state_e  sc_r, sc_n;
    logic [7:0] keycode_r, keycode_n;
    logic       key_valid_r, key_valid_n;
    logic       shoot_r, shoot_n;
    logic       is_make_s, is_break_s, is_ext_s;
    logic [7:0] hid_s;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (Clk),
        .rst        (Reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    // Scancode FSM and registered keycode outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sc_r        <= SC_WAIT;
            keycode_r   <= KEY_NONE;
            key_valid_r <= 1'b0;
            shoot_r     <= 1'b0;
        end else begin
            sc_r        <= sc_n;
            keycode_r   <= keycode_n;
            key_valid_r <= key_valid_n;
            shoot_r     <= shoot_n;
        end
    end

    // Prefix tracking, classifying each byte as a make or break, then the key update
    always_comb begin
        sc_n        = sc_r;
        keycode_n   = keycode_r;
        key_valid_n = 1'b0;
        shoot_n     = 1'b0;
        is_make_s   = 1'b0;
        is_break_s  = 1'b0;
        is_ext_s    = 1'b0;

        if (byte_valid) begin
            case (sc_r)
                SC_WAIT: begin
                    if (rx_byte == PS2_EXT) begin
                        sc_n = SC_E0;
                    end else if (rx_byte == PS2_BRK) begin
                        sc_n = SC_F0;
                    end else begin
                        is_make_s = 1'b1;
                    end
                end
                SC_E0: begin
                    // A repeated E0 keeps the extended prefix pending
                    if (rx_byte == PS2_EXT) begin
                        sc_n = SC_E0;
                    end else if (rx_byte == PS2_BRK) begin
                        sc_n = SC_E0F0;
                    end else begin
                        is_make_s = 1'b1;
                        is_ext_s  = 1'b1;
                        sc_n      = SC_WAIT;
                    end
                end
                SC_F0: begin
                    is_break_s = 1'b1;
                    sc_n       = SC_WAIT;
                end
                SC_E0F0: begin
                    is_break_s = 1'b1;
                    is_ext_s   = 1'b1;
                    sc_n       = SC_WAIT;
                end
                default: sc_n = SC_WAIT;
            endcase
        end else begin
            sc_n = sc_r;
        end

        hid_s = ps2_to_hid(is_ext_s, rx_byte);

        // Typematic repeats (hid == keycode) and unmapped codes leave everything unchanged
        if (is_make_s && hid_s != KEY_NONE && hid_s != keycode_r) begin
            keycode_n   = hid_s;
            key_valid_n = 1'b1;
            shoot_n     = (hid_s == KEY_SPACE);
        end else if (is_break_s && hid_s != KEY_NONE && hid_s == keycode_r) begin
            // Only releasing the currently held key clears it
            keycode_n   = KEY_NONE;
            key_valid_n = 1'b1;
        end else begin
            keycode_n   = keycode_r;
        end
    end

    assign keycode      = keycode_r;
    assign key_valid    = key_valid_r;
    assign shoot_bullet = shoot_r;

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Directed self-checking bench for ps2_keycode_decoder: drives PS/2 frames bit
// by bit and compares keycode and pulse counts with hand-computed values.
module tb_ps2_keycode_decoder;

    localparam int HALF = 12;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic       key_valid;
    logic       shoot_bullet;
    logic       frame_err;

    int checks;
    int errors;
    int kv_cnt;
    int sh_cnt;
    int fe_cnt;
    int kv0;
    int sh0;
    int fe0;

    ps2_keycode_decoder dut (
        .Clk          (clk),
        .Reset        (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .keycode      (keycode),
        .key_valid    (key_valid),
        .shoot_bullet (shoot_bullet),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            kv_cnt <= kv_cnt + int'(key_valid);
            sh_cnt <= sh_cnt + int'(shoot_bullet);
            fe_cnt <= fe_cnt + int'(frame_err);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ bad_par);
        send_bit(1'b1);
        repeat (30) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic snap();
        @(negedge clk);
        kv0 = kv_cnt;
        sh0 = sh_cnt;
        fe0 = fe_cnt;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        kv_cnt   = 0;
        sh_cnt   = 0;
        fe_cnt   = 0;
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_keycode", 32'(keycode), 32'h00);
        check("rst_pulses", 32'({key_valid, shoot_bullet, frame_err}), 32'h0);
        rst = 1'b0;
        repeat (20) @(posedge clk);

        // Reset mid-frame, frame during reset, then a clean 1C
        send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        rst = 1'b1;
        send_frame(8'h1C, 1'b0);
        check("in_rst_keycode", 32'(keycode), 32'h00);
        rst = 1'b0;
        snap();
        send_frame(8'h1C, 1'b0);
        check("after_rst_A", 32'(keycode), 32'h04);
        check("after_rst_kv", 32'(kv_cnt - kv0), 32'd1);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check("A_release", 32'(keycode), 32'h00);

        // Typematic W then break
        snap();
        send_frame(8'h1D, 1'b0);
        send_frame(8'h1D, 1'b0);
        send_frame(8'h1D, 1'b0);
        check("W_held", 32'(keycode), 32'h1A);
        check("W_kv_once", 32'(kv_cnt - kv0), 32'd1);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1D, 1'b0);
        check("W_release", 32'(keycode), 32'h00);
        check("W_kv_total", 32'(kv_cnt - kv0), 32'd2);

        // Space: press, repeat, release, press
        snap();
        send_frame(8'h29, 1'b0);
        send_frame(8'h29, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h29, 1'b0);
        send_frame(8'h29, 1'b0);
        check("space_shots", 32'(sh_cnt - sh0), 32'd2);
        check("space_held", 32'(keycode), 32'h2C);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h29, 1'b0);

        // Older key release does not clear newer key
        send_frame(8'h1C, 1'b0);
        send_frame(8'h23, 1'b0);
        check("D_after_A", 32'(keycode), 32'h07);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check("D_kept", 32'(keycode), 32'h07);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h23, 1'b0);
        check("D_release", 32'(keycode), 32'h00);

        // Extended up arrow
        snap();
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        check("up_make", 32'(keycode), 32'h52);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        check("up_break", 32'(keycode), 32'h00);
        check("up_no_shot", 32'(sh_cnt - sh0), 32'd0);
        check("no_err_yet", 32'(fe_cnt), 32'd0);

        // Parity error: one frame_err, keycode unchanged
        snap();
        send_frame(8'h1C, 1'b1);
        check("par_err", 32'(fe_cnt - fe0), 32'd1);
        check("par_keycode", 32'(keycode), 32'h00);
        check("par_no_kv", 32'(kv_cnt - kv0), 32'd0);

        // Pending break prefix survives a bad frame
        send_frame(8'h23, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h23, 1'b1);
        send_frame(8'h23, 1'b0);
        check("prefix_kept", 32'(keycode), 32'h00);

        // Timeout mid-frame, then recovery
        snap();
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        repeat (49000) @(posedge clk);
        @(negedge clk);
        check("tmo_early", 32'(fe_cnt - fe0), 32'd0);
        repeat (1200) @(posedge clk);
        @(negedge clk);
        check("tmo_err", 32'(fe_cnt - fe0), 32'd1);
        send_frame(8'h1B, 1'b0);
        check("S_after_tmo", 32'(keycode), 32'h16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
